io_uart: RTL
============

IO_UART -- requirements
Module: io_uart

Interface
REQ-001 Parameter CLK_DIV, default 26, clk cycles per UART bit; legal range 4..65535.
REQ-002 Parameter RX_DEPTH, default 4, RX FIFO entries; power of two, 2..16.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 io_req  input  1  CPU I/O request; held high by master until io_ack seen.
REQ-006 io_dir  input  1  transfer direction; encoding per shared DIRECTION_WRITE / DIRECTION_READ macros.
REQ-007 io_wdata  input  8  byte to transmit, valid while io_req high with write direction.
REQ-008 io_ack  output  1  transaction-complete pulse to CPU.
REQ-009 io_rdata  output  8  received byte, valid in io_ack cycle of a read.
REQ-010 uart_rx  input  1  asynchronous serial input, idle high.
REQ-011 uart_tx  output  1  serial output, idle high.

Function
REQ-012 Bus FSM states: IDLE, WR_WAIT, RD_WAIT, RELEASE.
REQ-013 IDLE: io_req=1 with write -> WR_WAIT; io_req=1 with read -> RD_WAIT; else stay.
REQ-014 WR_WAIT: when transmitter idle, load io_wdata into TX shifter, assert io_ack one cycle, -> RELEASE; else stall, io_ack=0.
REQ-015 Write acknowledge means byte accepted, not transmitted; back-to-back write stalls until previous frame, including stop bit, completes.
REQ-016 RD_WAIT: when RX FIFO non-empty, pop head, drive it on io_rdata, assert io_ack one cycle, -> RELEASE; empty FIFO stalls indefinitely.
REQ-017 RELEASE: io_ack=0; stay until io_req=0, then -> IDLE; a request still high after ack is never serviced twice.
REQ-018 io_ack is registered, high exactly one cycle per transaction; minimum latency io_req rise -> io_ack = 2 cycles.
REQ-019 io_rdata holds last read value until next read ack.
REQ-020 TX frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit exactly CLK_DIV cycles; uart_tx registered.
REQ-021 TX start bit begins the cycle after the load cycle; transmitter idle again after 10*CLK_DIV cycles.
REQ-022 uart_rx passes a 2-flop synchronizer before any use.
REQ-023 RX FSM states: R_IDLE, R_START, R_DATA, R_STOP.
REQ-024 R_IDLE: synchronized falling edge (1->0) -> R_START, counter loaded with CLK_DIV/2 (integer division).
REQ-025 R_START: at mid-bit sample; 0 -> R_DATA; 1 -> R_IDLE (glitch rejected, nothing pushed).
REQ-026 R_DATA: sample every CLK_DIV cycles, 8 bits LSB first -> R_STOP.
REQ-027 R_STOP: sample after CLK_DIV cycles; 1 -> push byte; 0 -> discard byte (framing error); both -> R_IDLE, no new start accepted until line seen high.
REQ-028 RX FIFO: RX_DEPTH entries, count width log2(RX_DEPTH)+1, pointers wrap modulo RX_DEPTH.
REQ-029 Push when full and no pop same cycle: new byte dropped, contents unchanged.
REQ-030 Push and pop same cycle: both performed, including when full or when count=1; push on empty with simultaneous read request: pop not taken that cycle (data readable next cycle).

Reset
REQ-031 While rst_n=0 at a clk edge: bus FSM IDLE, RX FSM R_IDLE, TX idle, io_ack=0, io_rdata=8'h00, uart_tx=1, FIFO empty, synchronizer flops=1.
REQ-032 Reset mid-frame aborts TX immediately (uart_tx=1 next cycle) and discards partial RX byte; pending transaction dropped without ack.

Verification (CLK_DIV=8, RX_DEPTH=4)
REQ-033 Write 8'hA5 from IDLE -> io_ack 2 cycles after io_req; uart_tx: 0,1,0,1,0,0,1,0,1,1 each 8 cycles.
REQ-034 Two back-to-back writes 8'h01, 8'h02 -> second io_ack not before 80 cycles after first load; frames contiguous.
REQ-035 Read on empty FIFO, then drive frame 8'h3C on uart_rx -> io_ack only after stop bit sampled, io_rdata=8'h3C.
REQ-036 Drive 5 valid frames 8'h10..8'h14 with no reads, then 5 reads -> first 4 return 8'h10..8'h13, 5th stalls (8'h14 dropped).
REQ-037 Frame 8'h55 with stop bit 0, then 2-cycle low glitch on uart_rx -> FIFO stays empty, read stalls.
REQ-038 Assert rst_n=0 mid TX frame and with io_req high -> uart_tx=1, io_ack=0, io_rdata=8'h00 after reset edge; request held after reset serviced normally.

Source files
------------

// File: rtl/io_uart_if.sv
// CPU-side I/O bus of the UART: a request/acknowledge handshake carrying one
// byte per transaction. The master (CPU) holds io_req until it sees io_ack.

`ifndef DIRECTION_WRITE
`define DIRECTION_WRITE 1'b1
`endif
`ifndef DIRECTION_READ
`define DIRECTION_READ 1'b0
`endif

interface io_uart_if;
    logic       io_req;
    logic       io_dir;
    logic [7:0] io_wdata;
    logic       io_ack;
    logic [7:0] io_rdata;

    modport master (
        output io_req,
        output io_dir,
        output io_wdata,
        input  io_ack,
        input  io_rdata
    );

    modport slave (
        input  io_req,
        input  io_dir,
        input  io_wdata,
        output io_ack,
        output io_rdata
    );
endinterface

// File: rtl/io_uart.sv
// Memory-less UART peripheral behind a simple CPU request/acknowledge bus.
// Writes hand one byte to an 8N1 transmitter; reads pop bytes captured by an
// oversampling-free mid-bit receiver into a small RX FIFO.

`ifndef DIRECTION_WRITE
`define DIRECTION_WRITE 1'b1
`endif
`ifndef DIRECTION_READ
`define DIRECTION_READ 1'b0
`endif

module io_uart #(
    parameter int CLK_DIV  = 26,
    parameter int RX_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    io_uart_if.slave bus,
    input  logic     uart_rx,
    output logic     uart_tx
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int AW    = $clog2(RX_DEPTH);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_BIT  = CNT_W'(CLK_DIV / 2);
    localparam logic [AW:0]      FIFO_FULL = (AW + 1)'(RX_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WR_WAIT,
        RD_WAIT,
        RELEASE
    } bus_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_t;

    // Bus side
    bus_state_t bus_state;

    // Transmitter
    logic             tx_busy;
    logic [CNT_W-1:0] tx_cnt;
    logic [3:0]       tx_bits;
    logic [8:0]       tx_shift;
    logic             tx_ready;
    logic             tx_load;

    // Receiver
    logic             rx_s1;
    logic             rx_s2;
    logic             rx_prev;
    logic             rx_fall;
    rx_state_t        rx_state;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bits;
    logic [7:0]       rx_shift;
    logic             rx_push;

    // RX FIFO
    logic [7:0]       fifo_mem [RX_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      fifo_count;
    logic             fifo_pop;
    logic             push_ok;

    // The transmitter can take a new byte when idle or in the very last cycle
    // of a stop bit, so back-to-back frames come out without an idle gap.
    assign tx_ready = !tx_busy || ((tx_cnt == '0) && (tx_bits == 4'd0));
    assign tx_load  = (bus_state == WR_WAIT) && tx_ready;

    // A pop only happens when the FIFO already held data at the start of the
    // cycle; a byte landing this cycle becomes readable one cycle later.
    assign fifo_pop = (bus_state == RD_WAIT) && (fifo_count != '0);

    // A full FIFO still accepts a byte when a pop frees a slot the same cycle.
    assign push_ok  = rx_push && ((fifo_count != FIFO_FULL) || fifo_pop);

    // Falling edge on the synchronized line marks a candidate start bit.
    assign rx_fall  = rx_prev && !rx_s2;

    // A received byte is delivered only when the stop bit samples high.
    assign rx_push  = (rx_state == R_STOP) && (rx_cnt == '0) && rx_s2;

    // Bus handshake FSM with registered acknowledge and read data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus_state    <= IDLE;
            bus.io_ack   <= 1'b0;
            bus.io_rdata <= 8'h00;
        end else begin
            bus.io_ack <= 1'b0;
            case (bus_state)
                IDLE: begin
                    if (bus.io_req) begin
                        if (bus.io_dir == `DIRECTION_WRITE) begin
                            bus_state <= WR_WAIT;
                        end else begin
                            bus_state <= RD_WAIT;
                        end
                    end
                end
                WR_WAIT: begin
                    if (tx_ready) begin
                        bus.io_ack <= 1'b1;
                        bus_state  <= RELEASE;
                    end
                end
                RD_WAIT: begin
                    if (fifo_count != '0) begin
                        bus.io_ack   <= 1'b1;
                        bus.io_rdata <= fifo_mem[rd_ptr];
                        bus_state    <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!bus.io_req) begin
                        bus_state <= IDLE;
                    end
                end
                default: begin
                    bus_state <= IDLE;
                end
            endcase
        end
    end

    // Transmit shifter: start bit leaves with the load, then 8 data bits LSB
    // first and the stop bit, each held for CLK_DIV cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_busy  <= 1'b0;
            tx_cnt   <= '0;
            tx_bits  <= 4'd0;
            tx_shift <= 9'h1FF;
            uart_tx  <= 1'b1;
        end else if (tx_load) begin
            uart_tx  <= 1'b0;
            tx_shift <= {1'b1, bus.io_wdata};
            tx_bits  <= 4'd9;
            tx_cnt   <= BIT_LAST;
            tx_busy  <= 1'b1;
        end else if (tx_busy) begin
            if (tx_cnt == '0) begin
                tx_cnt <= BIT_LAST;
                if (tx_bits == 4'd0) begin
                    tx_busy <= 1'b0;
                    uart_tx <= 1'b1;
                end else begin
                    uart_tx  <= tx_shift[0];
                    tx_shift <= {1'b1, tx_shift[8:1]};
                    tx_bits  <= tx_bits - 4'd1;
                end
            end else begin
                tx_cnt <= tx_cnt - CNT_W'(1);
            end
        end
    end

    // Two-flop synchronizer for the asynchronous serial input, plus one more
    // stage of history for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // Receive FSM: validate the start bit at mid-bit, then sample each data bit
    // and the stop bit one bit period apart.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state <= R_IDLE;
            rx_cnt   <= '0;
            rx_bits  <= 3'd0;
            rx_shift <= 8'h00;
        end else begin
            case (rx_state)
                R_IDLE: begin
                    if (rx_fall) begin
                        rx_state <= R_START;
                        rx_cnt   <= HALF_BIT;
                    end
                end
                R_START: begin
                    if (rx_cnt == '0) begin
                        if (!rx_s2) begin
                            rx_state <= R_DATA;
                            rx_cnt   <= BIT_LAST;
                            rx_bits  <= 3'd0;
                        end else begin
                            rx_state <= R_IDLE;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - CNT_W'(1);
                    end
                end
                R_DATA: begin
                    if (rx_cnt == '0) begin
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_cnt   <= BIT_LAST;
                        if (rx_bits == 3'd7) begin
                            rx_state <= R_STOP;
                        end else begin
                            rx_bits <= rx_bits + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - CNT_W'(1);
                    end
                end
                R_STOP: begin
                    if (rx_cnt == '0) begin
                        rx_state <= R_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    rx_state <= R_IDLE;
                end
            endcase
        end
    end

    // FIFO storage; contents need no reset because the count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= rx_shift;
        end
    end

    // FIFO pointers and occupancy; a push into a full FIFO without a pop is
    // dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, fifo_pop})
                2'b10:   fifo_count <= fifo_count + (AW + 1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW + 1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule
